// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if -- data-memory request/response bus of the MEM stage.
//
//   dmem_req    access request              (master -> slave)
//   dmem_we     1 = write, 0 = read         (master -> slave)
//   dmem_addr   access address, 32 bits     (master -> slave)
//   dmem_wdata  store data, 32 bits         (master -> slave)
//   dmem_ready  access completes this cycle (slave -> master)
//   dmem_rdata  load data, valid with ready (slave -> master)
//
// master: the pipeline MEM stage; slave: the data memory.
// ---------------------------------------------------------------------------
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- memory-access stage of a 5-stage RISC-V pipeline.
//
// Consumes the EX/MEM register, issues loads/stores to the data memory
// through a req/ready handshake, stalls the front of the pipeline while an
// access is outstanding, resolves the branch decision and fills MEM/WB.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   *_EXMEM               EX/MEM register fields (address/ALU result, store
//                         data, branch target, rd, branch/zero, control bits)
//   dmem                  mem_stage_if.master data-memory bus
//   stall_mem             freeze PC, IF/ID, ID/EX, EX/MEM this cycle
//   PCSrc, branch_target  branch decision and target (combinational)
//   *_MEMWB               registered MEM/WB fields
//   misalign_MEMWB        registered misaligned-access flag
//
// Build option: MEM_ALIGN_CHECK_EN -- when defined, accesses whose address
// is not word aligned issue no request and retire with misalign_MEMWB = 1
// and no register write. When undefined, misalign_MEMWB does not exist.
// ---------------------------------------------------------------------------
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] read_Address_EXMEM,
  input  logic [31:0] write_Data_EXMEM,
  input  logic [31:0] PC_EXMEM,
  input  logic [4:0]  rd_EXMEM,
  input  logic        branch_EXMEM,
  input  logic        zero_EXMEM,
  input  logic        memRead_EXMEM,
  input  logic        memWrite_EXMEM,
  input  logic        mem2reg_EXMEM,
  input  logic        RegWrite_EXMEM,
  mem_stage_if.master dmem,
  output logic        stall_mem,
  output logic        PCSrc,
  output logic [31:0] branch_target,
  output logic [31:0] read_data_MEMWB,
  output logic [31:0] alu_result_MEMWB,
  output logic [4:0]  rd_MEMWB,
  output logic        mem2reg_MEMWB,
  output logic        RegWrite_MEMWB
`ifdef MEM_ALIGN_CHECK_EN
  , output logic      misalign_MEMWB
`endif
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state_q;
  logic        access_s;
  logic        misalign_s;
  logic        req_s;
  logic        stall_s;
  logic        complete_s;
  logic [31:0] read_data_q;
  logic [31:0] alu_result_q;
  logic [4:0]  rd_q;
  logic        mem2reg_q;
  logic        reg_write_q;
  logic        misalign_q;

  // Misalignment detection (only meaningful with the alignment check built in)
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_s = access_s & (read_Address_EXMEM[1:0] != 2'b00);
`else
  assign misalign_s = 1'b0;
`endif

  // Request, stall and completion decode from FSM state and EX/MEM inputs
  always_comb begin
    access_s = memRead_EXMEM | memWrite_EXMEM;
    req_s    = 1'b0;
    case (state_q)
      IDLE:    req_s = access_s & ~misalign_s;
      WAIT:    req_s = 1'b1;
      default: req_s = 1'b0;
    endcase
    // ready is only meaningful while a request is presented
    stall_s    = req_s & ~dmem.dmem_ready;
    complete_s = req_s & dmem.dmem_ready;
  end

  // Request is held stable by upstream freezing EX/MEM while stalled;
  // a combined read+write is treated as a write.
  assign dmem.dmem_req   = req_s;
  assign dmem.dmem_we    = memWrite_EXMEM;
  assign dmem.dmem_addr  = read_Address_EXMEM;
  assign dmem.dmem_wdata = write_Data_EXMEM;

  assign stall_mem     = stall_s;
  assign PCSrc         = branch_EXMEM & zero_EXMEM;
  assign branch_target = PC_EXMEM;

  // Access FSM: leave IDLE only for a request the memory did not accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    state_q <= (req_s & ~dmem.dmem_ready) ? WAIT : IDLE;
        WAIT:    state_q <= dmem.dmem_ready ? IDLE : WAIT;
        default: state_q <= IDLE;
      endcase
    end
  end

  // MEM/WB register: bubble while stalled, otherwise capture the instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_q  <= 32'h0000_0000;
      alu_result_q <= 32'h0000_0000;
      rd_q         <= 5'd0;
      mem2reg_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      misalign_q   <= 1'b0;
    end else if (stall_s) begin
      // bubble: kill the write-back, keep data fields as they are
      mem2reg_q   <= 1'b0;
      reg_write_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      alu_result_q <= read_Address_EXMEM;
      rd_q         <= rd_EXMEM;
      mem2reg_q    <= mem2reg_EXMEM;
      reg_write_q  <= RegWrite_EXMEM & ~misalign_s;
      misalign_q   <= misalign_s;
      read_data_q  <= (complete_s & ~memWrite_EXMEM) ? dmem.dmem_rdata : 32'h0000_0000;
    end
  end

  assign read_data_MEMWB  = read_data_q;
  assign alu_result_MEMWB = alu_result_q;
  assign rd_MEMWB         = rd_q;
  assign mem2reg_MEMWB    = mem2reg_q;
  assign RegWrite_MEMWB   = reg_write_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_MEMWB   = misalign_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage.
// Each instruction is described by its kind and memory wait count; the
// expected bus, stall, branch and MEM/WB behaviour is derived per cycle from
// those, with a bench-side memory that answers after the chosen wait count.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BOTH = 3, K_BRANCH = 4;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] read_Address_EXMEM, write_Data_EXMEM, PC_EXMEM;
  logic [4:0]  rd_EXMEM;
  logic        branch_EXMEM, zero_EXMEM, memRead_EXMEM, memWrite_EXMEM;
  logic        mem2reg_EXMEM, RegWrite_EXMEM;
  logic        stall_mem, PCSrc;
  logic [31:0] branch_target, read_data_MEMWB, alu_result_MEMWB;
  logic [4:0]  rd_MEMWB;
  logic        mem2reg_MEMWB, RegWrite_MEMWB;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_MEMWB;
`endif

  mem_stage_if bus ();

  mem_stage dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .read_Address_EXMEM (read_Address_EXMEM),
    .write_Data_EXMEM   (write_Data_EXMEM),
    .PC_EXMEM           (PC_EXMEM),
    .rd_EXMEM           (rd_EXMEM),
    .branch_EXMEM       (branch_EXMEM),
    .zero_EXMEM         (zero_EXMEM),
    .memRead_EXMEM      (memRead_EXMEM),
    .memWrite_EXMEM     (memWrite_EXMEM),
    .mem2reg_EXMEM      (mem2reg_EXMEM),
    .RegWrite_EXMEM     (RegWrite_EXMEM),
    .dmem               (bus.master),
    .stall_mem          (stall_mem),
    .PCSrc              (PCSrc),
    .branch_target      (branch_target),
    .read_data_MEMWB    (read_data_MEMWB),
    .alu_result_MEMWB   (alu_result_MEMWB),
    .rd_MEMWB           (rd_MEMWB),
    .mem2reg_MEMWB      (mem2reg_MEMWB),
    .RegWrite_MEMWB     (RegWrite_MEMWB)
`ifdef MEM_ALIGN_CHECK_EN
    , .misalign_MEMWB   (misalign_MEMWB)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // expected MEM/WB contents
  logic [31:0] exp_rdata, exp_alu;
  logic [4:0]  exp_rd;
  logic        exp_m2r, exp_rw, exp_mis;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_memwb(input string tag);
    check_eq({tag, ".rdata"}, read_data_MEMWB, exp_rdata);
    check_eq({tag, ".alu"},   alu_result_MEMWB, exp_alu);
    check_eq({tag, ".rd"},    {27'd0, rd_MEMWB}, {27'd0, exp_rd});
    check_eq({tag, ".m2r"},   {31'd0, mem2reg_MEMWB}, {31'd0, exp_m2r});
    check_eq({tag, ".rw"},    {31'd0, RegWrite_MEMWB}, {31'd0, exp_rw});
`ifdef MEM_ALIGN_CHECK_EN
    check_eq({tag, ".mis"},   {31'd0, misalign_MEMWB}, {31'd0, exp_mis});
`endif
  endtask

  task automatic clear_exmem();
    read_Address_EXMEM = 32'd0; write_Data_EXMEM = 32'd0; PC_EXMEM = 32'd0;
    rd_EXMEM = 5'd0; branch_EXMEM = 1'b0; zero_EXMEM = 1'b0;
    memRead_EXMEM = 1'b0; memWrite_EXMEM = 1'b0;
    mem2reg_EXMEM = 1'b0; RegWrite_EXMEM = 1'b0;
    bus.dmem_ready = 1'b0; bus.dmem_rdata = 32'd0;
  endtask

  // Run one instruction through MEM, the memory answering after nwait cycles.
  task automatic run_instr(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] pc, input logic [4:0] rd, input logic zero,
                           input int nwait, input logic [31:0] rdv);
    logic mr, mw, br, m2r, rw, acc, mis, req;
    int   n;
    mr  = (kind == K_LOAD) || (kind == K_BOTH);
    mw  = (kind == K_STORE) || (kind == K_BOTH);
    br  = (kind == K_BRANCH);
    m2r = mr;
    rw  = (kind == K_ALU) || (kind == K_LOAD) || (kind == K_BOTH);
    acc = mr | mw;
    mis = MIS_EN && acc && (addr[1:0] != 2'b00);
    req = acc && !mis;
    n   = req ? nwait : 0;
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      if (c == 0) begin
        read_Address_EXMEM = addr; write_Data_EXMEM = wd; PC_EXMEM = pc;
        rd_EXMEM = rd; branch_EXMEM = br; zero_EXMEM = zero;
        memRead_EXMEM = mr; memWrite_EXMEM = mw;
        mem2reg_EXMEM = m2r; RegWrite_EXMEM = rw;
      end
      // without a request, ready is noise the stage must ignore
      bus.dmem_ready = req ? (c == n) : 1'($urandom_range(1, 0));
      bus.dmem_rdata = (c == n) ? rdv : $urandom;
      #1;
      check_eq("req",    {31'd0, bus.dmem_req}, {31'd0, req});
      check_eq("stall",  {31'd0, stall_mem}, {31'd0, (req && c < n)});
      if (req) check_eq("we", {31'd0, bus.dmem_we}, {31'd0, mw});
      else     check_eq("we_idle", {31'd0, bus.dmem_we}, {31'd0, mw});
      check_eq("addr",   bus.dmem_addr, addr);
      check_eq("wdata",  bus.dmem_wdata, wd);
      check_eq("pcsrc",  {31'd0, PCSrc}, {31'd0, (br & zero)});
      check_eq("target", branch_target, pc);
      @(posedge clk);
      #1;
      if (c < n) begin
        exp_rw = 1'b0; exp_m2r = 1'b0; exp_mis = 1'b0;
      end else begin
        exp_alu = addr; exp_rd = rd; exp_m2r = m2r;
        exp_rw  = rw && !mis;
        exp_mis = mis;
        exp_rdata = (req && !mw) ? rdv : 32'd0;
      end
      check_memwb(c < n ? "bubble" : "retire");
    end
  endtask

  task automatic reset_model();
    exp_rdata = 32'd0; exp_alu = 32'd0; exp_rd = 5'd0;
    exp_m2r = 1'b0; exp_rw = 1'b0; exp_mis = 1'b0;
  endtask

  initial begin
    int kind;
    logic [31:0] a;
    rst_n = 1'b0;
    clear_exmem();
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_memwb("reset");
    check_eq("reset.req",   {31'd0, bus.dmem_req}, 32'd0);
    check_eq("reset.stall", {31'd0, stall_mem}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed cases
    run_instr(K_LOAD,   32'h10, 32'h0, 32'h100, 5'd5, 1'b0, 0, 32'hDEADBEEF);
    run_instr(K_STORE,  32'h20, 32'h12345678, 32'h104, 5'd7, 1'b0, 3, 32'h0BAD0BAD);
    run_instr(K_BRANCH, 32'h0,  32'h0, 32'h40, 5'd0, 1'b1, 0, 32'h0);
    run_instr(K_BOTH,   32'h24, 32'hCAFEF00D, 32'h108, 5'd9, 1'b0, 0, 32'h55AA55AA);
    run_instr(K_LOAD,   32'h13, 32'h0, 32'h10C, 5'd11, 1'b0, 1, 32'h13131313);
    run_instr(K_LOAD,   32'h30, 32'h0, 32'h110, 5'd12, 1'b0, 2, 32'hA5A5A5A5);
    run_instr(K_LOAD,   32'h34, 32'h0, 32'h114, 5'd13, 1'b0, 0, 32'h5A5A5A5A);

    // reset in WAIT after 2 wait cycles
    @(negedge clk);
    read_Address_EXMEM = 32'h44; memRead_EXMEM = 1'b1; mem2reg_EXMEM = 1'b1;
    RegWrite_EXMEM = 1'b1; rd_EXMEM = 5'd3; bus.dmem_ready = 1'b0;
    repeat (2) begin
      #1 check_eq("pre_rst.stall", {31'd0, stall_mem}, 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    clear_exmem();
    reset_model();
    #1;
    check_memwb("rst_wait");
    check_eq("rst_wait.req",   {31'd0, bus.dmem_req}, 32'd0);
    check_eq("rst_wait.stall", {31'd0, stall_mem}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // a non-memory instruction must see no request, i.e. the FSM is IDLE
    run_instr(K_ALU, 32'h77, 32'h0, 32'h200, 5'd4, 1'b1, 0, 32'h0);

    // randomized sequence
    for (int i = 0; i < 200; i++) begin
      kind = int'($urandom_range(K_BRANCH, K_ALU));
      a = $urandom;
      if ($urandom_range(3, 0) != 0) a[1:0] = 2'b00;
      run_instr(kind, a, $urandom, $urandom, 5'($urandom), 1'($urandom),
                int'($urandom_range(3, 0)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage RISC-V pipeline; consumer of the EX/MEM pipeline register. Issues load/store requests to the data memory over a req/ready handshake, stalls the front of the pipeline while an access is outstanding, resolves the branch decision (PCSrc), and drives the MEM/WB pipeline register toward write-back.

## Interface
- No parameters; data width 32, register index width 5.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- read_Address_EXMEM  in  32  ALU result; memory address for loads and stores
- write_Data_EXMEM  in  32  store data
- PC_EXMEM  in  32  branch target
- rd_EXMEM  in  5  destination register
- branch_EXMEM, zero_EXMEM  in  1 each  branch instruction flag, ALU zero
- memRead_EXMEM, memWrite_EXMEM, mem2reg_EXMEM, RegWrite_EXMEM  in  1 each  control bits
- dmem_req  out  1  access request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  32  access address
- dmem_wdata  out  32  store data
- dmem_ready  in  1  memory completes the access this cycle
- dmem_rdata  in  32  load data, valid when dmem_ready is high
- stall_mem  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
- PCSrc  out  1  take branch (branch_EXMEM & zero_EXMEM)
- branch_target  out  32  equals PC_EXMEM
- read_data_MEMWB, alu_result_MEMWB  out  32 each  registered load data, registered address/ALU result
- rd_MEMWB  out  5;  mem2reg_MEMWB, RegWrite_MEMWB  out  1 each  registered
- misalign_MEMWB  out  1  registered misaligned-access flag (present only with MEM_ALIGN_CHECK_EN)

## Operation
- access = memRead_EXMEM | memWrite_EXMEM. When both are set, the access is a write.
- FSM states: IDLE, WAIT.
  - IDLE: dmem_req = access (combinational). If req & ready → complete, stay IDLE. If req & ~ready → WAIT.
  - WAIT: dmem_req = 1. On ready → complete, go to IDLE.
- dmem_we, dmem_addr and dmem_wdata are driven directly from the EX/MEM inputs. Upstream holds EX/MEM stable while stall_mem = 1, so the request stays stable until completion.
- stall_mem = dmem_req & ~dmem_ready.
- MEM/WB update on every clock edge:
  - stall_mem = 1: load a bubble. RegWrite_MEMWB = 0, mem2reg_MEMWB = 0; other fields hold.
  - otherwise: capture alu_result, rd, mem2reg, RegWrite. read_data_MEMWB = dmem_rdata on a completing read, 0 on a write or on a non-memory instruction.
- dmem_ready while dmem_req = 0 is ignored.
- PCSrc and branch_target are combinational and are not gated by stall_mem. A branch never accesses memory.

## Timing
- Zero-wait access (ready in the request cycle): no stall; result appears in MEM/WB at the next edge.
- N wait cycles: stall_mem is high for exactly N cycles; MEM/WB receives N bubbles, then the result.
- Non-memory instruction: 1-cycle pass-through to MEM/WB.
- Reset (asynchronous, at any time including in WAIT): FSM → IDLE; every MEM/WB output → 0, including misalign_MEMWB.
  - dmem_req and stall_mem are combinational from the FSM and the EX/MEM inputs. They read 0 once the upstream EX/MEM register has also reset to 0.
  - The memory abandons any in-flight access when rst_n is asserted.
- Back-to-back accesses: a new request is issued in the cycle after completion, with no dead cycle.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - An access with read_Address_EXMEM[1:0] ≠ 0 is misaligned. It issues no request (dmem_req = 0, no stall).
  - On the next edge: misalign_MEMWB = 1, RegWrite_MEMWB = 0, read_data_MEMWB = 0.
  - misalign_MEMWB is 0 for every other instruction.
- MEM_ALIGN_CHECK_EN undefined: no alignment check; all addresses are passed through unchanged. The misalign_MEMWB port does not exist.

## Test plan
- Load from 0x10, ready in the request cycle, rdata = 0xDEADBEEF, rd = 5 → no stall; next edge read_data_MEMWB = 0xDEADBEEF, rd_MEMWB = 5, RegWrite_MEMWB = 1.
- Store 0x12345678 to 0x20, ready after 3 wait cycles → stall_mem high for 3 cycles, dmem_we = 1 and address/data held throughout; 3 bubbles with RegWrite_MEMWB = 0, then the store retires.
- Branch with zero = 1, PC_EXMEM = 0x40 → PCSrc = 1, branch_target = 0x40 in the same cycle; dmem_req = 0.
- Reset asserted in WAIT after 2 wait cycles → FSM in IDLE; all MEM/WB outputs 0; with the EX/MEM register also reset, dmem_req = 0 and stall_mem = 0.
- memRead and memWrite both set, ready immediately → dmem_we = 1; read_data_MEMWB = 0.
- With MEM_ALIGN_CHECK_EN: load from 0x13 → dmem_req = 0; next edge misalign_MEMWB = 1, RegWrite_MEMWB = 0.
